// File: rtl/filter_line_sched.sv
// Line scheduler ahead of the separable Gaussian filter: buffers upstream pixels in a FIFO
// and releases one whole line per unbroken burst, with a forced idle gap between bursts.
module filter_line_sched #(
  parameter int LINE_W    = 640,
  parameter int NUM_LINES = 512,
  parameter int LINE_GAP  = 16,
  parameter int ASIZE     = 10,
  parameter int TIMEOUT   = 1 << 20
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       s_axis_tvalid_i,
  input  logic       s_axis_tlast_i,
  output logic       s_axis_tready_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  output logic       m_axis_tkeep_o,
  output logic       m_axis_tlast_o,
  input  logic       f_tvalid_i,
  input  logic       f_tlast_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_tlast_o,
  output logic       err_timeout_o
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int CW    = ASIZE + 1;
  localparam int PW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int LW    = $clog2(NUM_LINES + 1);
  localparam int GW    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PIX_LAST = PW'(LINE_W - 1);
  localparam logic [LW-1:0] LINES_N  = LW'(NUM_LINES);
  localparam logic [GW-1:0] GAP_LAST = GW'(LINE_GAP - 1);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LINE = CW'(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [7:0]       r_mem [DEPTH];
  logic [ASIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_in_cnt, r_rd_cnt;
  logic [LW-1:0]    r_line_cnt, r_fout_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [TW-1:0]    r_wd_cnt;
  logic [7:0]       r_tdata;
  logic             r_tvalid, r_tlast;
  logic             r_err_tlast, r_err_timeout;

  logic w_start, w_tready, w_wr, w_rd, w_fout;

  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_tready = (r_state != S_IDLE) && (r_state != S_DONE) && (r_count != CNT_FULL);
  assign w_wr     = s_axis_tvalid_i && w_tready;
  assign w_rd     = (r_state == S_BURST);
  assign w_fout   = f_tvalid_i && f_tlast_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_WAIT;
      S_WAIT:  if (r_count >= CNT_LINE) w_next = S_BURST;
      S_BURST: if (r_rd_cnt == PIX_LAST) w_next = S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_next = (r_line_cnt == LINES_N) ? S_FLUSH : S_WAIT;
      S_FLUSH: if (r_fout_cnt == LINES_N || r_wd_cnt == WD_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO storage: reads only ever target words already written, so no bypass is needed.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= s_axis_tdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_tvalid <= w_rd;
      r_tlast  <= w_rd && (r_rd_cnt == PIX_LAST);
      r_tdata  <= w_rd ? r_mem[r_rd_ptr] : '0;
    end
  end

  // Frame bookkeeping; the filter-output line count runs in every state once a frame starts.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || w_start) begin
      r_in_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_line_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_fout_cnt    <= '0;
      r_err_tlast   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_wr) begin
        r_in_cnt <= (r_in_cnt == PIX_LAST) ? '0 : r_in_cnt + 1'b1;
        if (s_axis_tlast_i != (r_in_cnt == PIX_LAST)) r_err_tlast <= 1'b1;
      end
      if (w_rd) begin
        r_rd_cnt <= (r_rd_cnt == PIX_LAST) ? '0 : r_rd_cnt + 1'b1;
        if (r_rd_cnt == PIX_LAST) r_line_cnt <= r_line_cnt + 1'b1;
      end
      if (r_state == S_GAP) r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
      else                  r_gap_cnt <= '0;
      if (r_state == S_FLUSH) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                    r_wd_cnt <= '0;
      if (r_state == S_FLUSH && r_fout_cnt != LINES_N && r_wd_cnt == WD_LAST)
        r_err_timeout <= 1'b1;
      if (w_fout && r_fout_cnt != LINES_N) r_fout_cnt <= r_fout_cnt + 1'b1;
    end
  end

  assign s_axis_tready_o = w_tready;
  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign m_axis_tkeep_o  = r_tvalid;
  assign m_axis_tlast_o  = r_tlast;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_DONE);
  assign err_tlast_o     = r_err_tlast;
  assign err_timeout_o   = r_err_timeout;

endmodule

// File: tb/tb_filter_line_sched.sv
// Scoreboard bench for filter_line_sched: stimulus pushes accepted pixels, a monitor pops
// them against each output beat and checks burst shape, gaps, tlast and frame completion.
module tb_filter_line_sched;

  localparam int LW  = 8;
  localparam int NL  = 4;
  localparam int GAP = 4;
  localparam int AS  = 4;
  localparam int TO  = 64;

  logic       clk, rstn, s_start;
  logic [7:0] s_tdata, m_tdata;
  logic       s_tvalid, s_tlast, s_tready;
  logic       m_tvalid, m_tkeep, m_tlast;
  logic       f_tvalid, f_tlast;
  logic       busy, done, err_tl, err_to;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int run = 0, idle = 1000, out_lines = 0, done_cnt = 0, cyc = 0, last_tlast_cyc = 0;
  int man_total = 0, man_done = 0;
  logic stub_en;

  filter_line_sched #(
    .LINE_W(LW), .NUM_LINES(NL), .LINE_GAP(GAP), .ASIZE(AS), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(s_start),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tkeep_o(m_tkeep),
    .m_axis_tlast_o(m_tlast),
    .f_tvalid_i(f_tvalid), .f_tlast_i(f_tlast),
    .busy_o(busy), .done_o(done), .err_tlast_o(err_tl), .err_timeout_o(err_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int f, input int i);
    return 8'(f * 29 + i * 7 + 3);
  endfunction

  // Monitor: pops the scoreboard on every output beat.
  initial forever begin
    logic [7:0] want;
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      run  = 0;
      idle = 1000;
    end else if (m_tvalid) begin
      chk("tkeep", m_tkeep, 1);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("tdata", m_tdata, want);
      end
      chk("tlast_pos", m_tlast, run == LW - 1);
      if (run == 0) chk("gap_min", idle >= GAP, 1);
      run++;
      idle = 0;
      if (m_tlast) begin
        out_lines++;
        last_tlast_cyc = cyc;
      end
    end else begin
      if (run != 0) begin
        chk("burst_len", run, LW);
        run = 0;
      end
      chk("idle_tlast", m_tlast, 0);
      chk("idle_tkeep", m_tkeep, 0);
      idle++;
    end
    if (rstn && done) done_cnt++;
  end

  // Filter stub: one output-line pulse per burst tlast, plus manually requested pulses.
  initial begin
    f_tvalid = 1'b0;
    f_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      f_tvalid = 1'b0;
      f_tlast  = 1'b0;
      if (rstn) begin
        if (man_done < man_total) begin
          f_tvalid = 1'b1;
          f_tlast  = 1'b1;
          man_done++;
        end else if (stub_en && m_tvalid && m_tlast) begin
          f_tvalid = 1'b1;
          f_tlast  = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic send(input logic [7:0] d, input logic l);
    int g;
    @(negedge clk);
    s_start  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    g = 0;
    while (!s_tready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("send_accept", s_tready, 1);
    if (s_tready) exp_q.push_back(d);
  endtask

  task automatic idle_in(input logic st);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_start  = st;
  endtask

  task automatic start_frame();
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_tlast_cleared", err_tl, 0);
    chk("err_timeout_cleared", err_to, 0);
  endtask

  task automatic run_frame(input int f, input int n, input bit toggle, input int bad_line);
    for (int i = 0; i < n; i++) begin
      int pos, line;
      pos  = i % LW;
      line = i / LW;
      send(pix(f, i), (line == bad_line) ? (pos == 5) : (pos == LW - 1));
      if (toggle) idle_in(i == 12);
    end
    idle_in(1'b0);
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (!done && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done_seen"}, done, 1);
    if (done) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_idle_after_done"}, busy, 0);
    end
  endtask

  task automatic wait_lines(input int target);
    int g;
    g = 0;
    while (out_lines < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("out_lines_reached", out_lines >= target, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tkeep"}, m_tkeep, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_tlast"}, err_tl, 0);
    chk({tag, "_err_timeout"}, err_to, 0);
  endtask

  initial begin
    int base, snap;
    rstn = 1'b0; s_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    stub_en = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back frame.
    start_frame();
    run_frame(1, NL * LW, 1'b0, -1);
    wait_done("f1");
    chk("f1_err_tlast", err_tl, 0);
    chk("f1_err_timeout", err_to, 0);

    // Upstream valid toggling; a start pulse mid-frame must be ignored.
    start_frame();
    run_frame(2, NL * LW, 1'b1, -1);
    wait_done("f2");

    // Fill FIFO to depth 16 during FLUSH, then carry the surplus into the next frame.
    stub_en = 1'b0;
    base = out_lines;
    start_frame();
    run_frame(3, NL * LW + 16, 1'b0, -1);
    wait_lines(base + NL);
    repeat (GAP + 2) @(negedge clk);
    chk("fifo_full_tready", s_tready, 0);
    chk("fifo_full_busy", busy, 1);
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("fifo_full_hold", s_tready, 0);
    end
    s_tvalid = 1'b0;
    man_total = man_total + NL;
    wait_done("f3");
    stub_en = 1'b1;
    start_frame();
    run_frame(4, NL * LW - 16, 1'b0, -1);
    wait_done("f4");

    // Misplaced upstream tlast on line 2.
    start_frame();
    run_frame(5, NL * LW, 1'b0, 2);
    chk("err_tlast_set", err_tl, 1);
    wait_done("f5");
    chk("err_tlast_sticky", err_tl, 1);

    // FLUSH watchdog.
    stub_en = 1'b0;
    start_frame();
    run_frame(6, NL * LW, 1'b0, -1);
    begin
      int g;
      g = 0;
      while (!err_to && g < 500) begin
        @(negedge clk);
        g++;
      end
    end
    chk("timeout_set", err_to, 1);
    chk("timeout_delay", cyc - last_tlast_cyc, GAP + TO);
    chk("timeout_done", done, 1);
    @(negedge clk);
    chk("timeout_done_one_cycle", done, 0);
    chk("timeout_sticky", err_to, 1);
    chk("timeout_idle", busy, 0);
    stub_en = 1'b1;

    // Reset in the middle of a burst.
    start_frame();
    run_frame(7, LW, 1'b0, -1);
    begin
      int g;
      g = 0;
      while (!m_tvalid && g < 50) begin
        @(negedge clk);
        g++;
      end
    end
    chk("mid_burst_reached", m_tvalid, 1);
    repeat (2) @(negedge clk);
    snap = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cnt, snap);
    chk("idle_after_abort", busy, 0);

    // Clean frame after abort.
    start_frame();
    run_frame(8, NL * LW, 1'b0, -1);
    wait_done("f8");
    chk("f8_err_tlast", err_tl, 0);
    chk("f8_err_timeout", err_to, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_total", done_cnt, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
